vector_accumulate_unit: RTL

VECTOR_ACCUMULATE_UNIT -- requirements
Module: vector_accumulate_unit

---
 rtl/vector_accumulate_unit.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/vector_accumulate_unit.sv
// vector_accumulate_unit
// Per-chain lane-wise accumulator that sits after a vector reduce stage.
// Each chain context holds a firmware mode, an open-frame flag and an
// N-lane accumulator. Mode 1 sums every vector of a frame and emits the
// total on the end-of-frame vector; any other mode passes vectors through.
// With tracing low the unit is in configuration: writes addressed to
// PERSONAL_CONFIG_ID load the mode of chainId_in and reset that chain.
//
// Optional feature: define VAU_SATURATE_EN to make mode-1 lane additions
// signed saturating instead of wrapping modulo 2^DATA_WIDTH.
//
// Handshake: there is no back-pressure. A vector is accepted on every rising
// edge where valid_in is 1 (and tracing is 1); valid_out is a one-cycle
// qualifier on vector_out, which always appears exactly one clock later.
module vector_accumulate_unit #(
    parameter int N                  = 8,
    parameter int DATA_WIDTH         = 32,
    parameter int MAX_CHAINS         = 4,
    parameter int PERSONAL_CONFIG_ID = 0,
    localparam int CW                = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1,
    localparam int VW                = N * DATA_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_in,
    input  logic          eof_in,
    input  logic          bof_in,
    input  logic [CW-1:0] chainId_in,
    input  logic          tracing,
    input  logic [7:0]    configId,
    input  logic [7:0]    configData,
    input  logic [VW-1:0] vector_in,
    output logic          valid_out,
    output logic          eof_out,
    output logic          bof_out,
    output logic [CW-1:0] chainId_out,
    output logic [VW-1:0] vector_out
);

    localparam logic [7:0] MODE_ACC = 8'd1;

    // Per-chain context
    logic [7:0]    mode_q [MAX_CHAINS];
    logic          open_q [MAX_CHAINS];
    logic [VW-1:0] acc_q  [MAX_CHAINS];

    logic          chain_ok;
    logic [7:0]    cur_mode;
    logic          cur_open;
    logic [VW-1:0] cur_acc;
    logic          acc_mode;
    logic          cfg_hit;
    logic [VW-1:0] next_vec;

    // One lane of the mode-1 sum; wraps unless saturation is compiled in.
    function automatic logic [DATA_WIDTH-1:0] lane_add(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH-1:0] s;
        s = a + b;
`ifdef VAU_SATURATE_EN
        // Overflow only when both operands share a sign the result lacks.
        if ((a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) && (s[DATA_WIDTH-1] != a[DATA_WIDTH-1])) begin
            s = a[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
`endif
        return s;
    endfunction

    // An out-of-range chain id (non power-of-two MAX_CHAINS) reads as a
    // closed pass-through chain and never writes state.
    assign chain_ok = (32'(chainId_in) < MAX_CHAINS);
    assign cfg_hit  = (configId == 8'(PERSONAL_CONFIG_ID));

    // Select the context addressed by the incoming vector.
    always_comb begin
        cur_mode = 8'd0;
        cur_open = 1'b0;
        cur_acc  = '0;
        if (chain_ok) begin
            cur_mode = mode_q[chainId_in];
            cur_open = open_q[chainId_in];
            cur_acc  = acc_q[chainId_in];
        end
    end

    assign acc_mode = (cur_mode == MODE_ACC);

    // Next accumulator value: restart on bof or on a closed chain (implicit bof).
    always_comb begin
        next_vec = vector_in;
        if (cur_open && !bof_in) begin
            for (int i = 0; i < N; i++) begin
                next_vec[i*DATA_WIDTH +: DATA_WIDTH] =
                    lane_add(cur_acc[i*DATA_WIDTH +: DATA_WIDTH],
                             vector_in[i*DATA_WIDTH +: DATA_WIDTH]);
            end
        end
    end

    // Chain context update: configuration writes and mode-1 accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < MAX_CHAINS; c++) begin
                mode_q[c] <= 8'd0;
                open_q[c] <= 1'b0;
                acc_q[c]  <= '0;
            end
        end else if (chain_ok) begin
            if (!tracing) begin
                if (cfg_hit) begin
                    mode_q[chainId_in] <= configData;
                    open_q[chainId_in] <= 1'b0;
                    acc_q[chainId_in]  <= '0;
                end
            end else if (acc_mode && valid_in) begin
                if (eof_in) begin
                    open_q[chainId_in] <= 1'b0;
                    acc_q[chainId_in]  <= '0;
                end else begin
                    open_q[chainId_in] <= 1'b1;
                    acc_q[chainId_in]  <= next_vec;
                end
            end
        end
    end

    // Registered outputs; frame markers and chain id always follow the input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out   <= 1'b0;
            eof_out     <= 1'b0;
            bof_out     <= 1'b0;
            chainId_out <= '0;
            vector_out  <= '0;
        end else begin
            eof_out     <= eof_in;
            bof_out     <= bof_in;
            chainId_out <= chainId_in;
            if (!tracing) begin
                valid_out <= 1'b0;
            end else if (acc_mode) begin
                valid_out <= valid_in && eof_in;
                if (valid_in && eof_in) begin
                    vector_out <= next_vec;
                end
            end else begin
                valid_out  <= valid_in;
                vector_out <= vector_in;
            end
        end
    end

endmodule
